// File: rtl/pipe_width_fifo.sv
// pipe_width_fifo: single-clock FIFO with power-of-2 width conversion and registered block throttle flags.
// Optional sticky overflow/underflow flags are compiled in when PIPE_FIFO_STATS_EN is defined.
module pipe_width_fifo #(
    parameter int WR_W      = 32,
    parameter int RD_W      = 256,
    parameter int WR_DEPTH  = 1024,
    parameter int BLK_WR    = 128,
    parameter int BLK_RD    = 128,
    parameter int MSB_FIRST = 0
) (
    input  logic                                  okClk,
    input  logic                                  reset_n,
    input  logic [WR_W-1:0]                       din,
    input  logic                                  wr_en,
    input  logic                                  rd_en,
`ifdef PIPE_FIFO_STATS_EN
    input  logic                                  clr_stats,
    output logic                                  ovf,
    output logic                                  udf,
`endif
    output logic [RD_W-1:0]                       dout,
    output logic                                  valid,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(WR_DEPTH):0]             wr_count,
    output logic [$clog2(WR_DEPTH*WR_W/RD_W):0]   rd_count,
    output logic                                  in_ready,
    output logic                                  out_ready
);

    localparam int G        = (WR_W < RD_W) ? WR_W : RD_W;
    localparam int M        = (WR_W < RD_W) ? RD_W : WR_W;
    localparam int WR_U     = WR_W / G;
    localparam int RD_U     = RD_W / G;
    localparam int RATIO    = M / G;
    localparam int UNITS    = WR_DEPTH * WR_U;
    localparam int RD_DEPTH = UNITS / RD_U;
    localparam int ROWS     = UNITS / RATIO;
    localparam int PW       = $clog2(UNITS);
    localparam int OW       = PW + 1;
    localparam int SHIFT    = $clog2(RATIO);
    localparam int RW       = PW - SHIFT;
    localparam int SW       = (RATIO > 1) ? SHIFT : 1;
    localparam int WCW      = $clog2(WR_DEPTH) + 1;
    localparam int RCW      = $clog2(RD_DEPTH) + 1;

    // Storage rows are one wide word; the narrow side addresses a G-bit slot inside a row.
    logic [M-1:0]    r_mem [ROWS];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_occ;
    logic [RD_W-1:0] r_dout;
    logic            r_valid;
    logic            r_in_ready;
    logic            r_out_ready;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [RW-1:0]   w_wr_row;
    logic [RW-1:0]   w_rd_row;
    logic [RD_W-1:0] w_rd_data;
    logic [WCW-1:0]  w_wr_count;
    logic [RCW-1:0]  w_rd_count;

    assign w_full     = (OW'(UNITS) - r_occ) < OW'(WR_U);
    assign w_empty    = r_occ < OW'(RD_U);
    assign w_wr_acc   = wr_en && !w_full;
    assign w_rd_acc   = rd_en && !w_empty;
    assign w_wr_row   = RW'(r_wr_ptr >> SHIFT);
    assign w_rd_row   = RW'(r_rd_ptr >> SHIFT);
    assign w_wr_count = WCW'(r_occ >> $clog2(WR_U));
    assign w_rd_count = RCW'(r_occ >> $clog2(RD_U));

    // Slot order inside a row: first-in slice at the bottom, or at the top when MSB_FIRST.
    // RATIO is a power of 2, so RATIO-1-k is just the bitwise inverse of k.
    generate
        if (WR_W < RD_W) begin : g_narrow_wr
            logic [SW-1:0] w_wr_slot;
            assign w_wr_slot = (MSB_FIRST != 0) ? ~SW'(r_wr_ptr) : SW'(r_wr_ptr);
            always_ff @(posedge okClk) begin
                if (w_wr_acc) begin
                    r_mem[w_wr_row][int'(w_wr_slot)*G +: G] <= din;
                end
            end
            assign w_rd_data = r_mem[w_rd_row];
        end else if (WR_W > RD_W) begin : g_wide_wr
            logic [SW-1:0] w_rd_slot;
            assign w_rd_slot = (MSB_FIRST != 0) ? ~SW'(r_rd_ptr) : SW'(r_rd_ptr);
            always_ff @(posedge okClk) begin
                if (w_wr_acc) begin
                    r_mem[w_wr_row] <= din;
                end
            end
            assign w_rd_data = r_mem[w_rd_row][int'(w_rd_slot)*G +: G];
        end else begin : g_equal
            always_ff @(posedge okClk) begin
                if (w_wr_acc) begin
                    r_mem[w_wr_row] <= din;
                end
            end
            assign w_rd_data = r_mem[w_rd_row];
        end
    endgenerate

    // Accept decisions use pre-edge occupancy; a simultaneous read never frees room for a write.
    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_ready <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(WR_U);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(RD_U);
                r_dout   <= w_rd_data;
            end
            r_occ       <= r_occ + (w_wr_acc ? OW'(WR_U) : OW'(0))
                                 - (w_rd_acc ? OW'(RD_U) : OW'(0));
            r_valid     <= w_rd_acc;
            r_in_ready  <= w_wr_count <= WCW'(WR_DEPTH - BLK_WR);
            r_out_ready <= w_rd_count >= RCW'(BLK_RD);
        end
    end

`ifdef PIPE_FIFO_STATS_EN
    logic r_ovf;
    logic r_udf;

    // A set wins over a clear arriving in the same cycle.
    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !clr_stats) || (wr_en && w_full);
            r_udf <= (r_udf && !clr_stats) || (rd_en && w_empty);
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign wr_count  = w_wr_count;
    assign rd_count  = w_rd_count;
    assign in_ready  = r_in_ready;
    assign out_ready = r_out_ready;

endmodule

// File: tb/tb_pipe_width_fifo.sv
// tb_pipe_width_fifo: randomized self-checking bench for pipe_width_fifo against a queue-based model.
// Instance a: 32->256 default; b: 64->32 LSB-first; c: 32->64 MSB-first.
module tb_pipe_width_fifo;

    logic okClk = 1'b0;
    always #5 okClk = ~okClk;

    logic reset_n;
    logic tb_clr;
    int   total = 0;
    int   bad   = 0;

    logic [31:0]  a_din;
    logic         a_wr, a_rd;
    logic [255:0] a_dout;
    logic         a_valid, a_full, a_empty, a_inr, a_outr;
    logic [10:0]  a_wc;
    logic [7:0]   a_rc;
    logic         a_ovf, a_udf;

    logic [63:0]  b_din;
    logic         b_wr, b_rd;
    logic [31:0]  b_dout;
    logic         b_valid, b_full, b_empty, b_inr, b_outr;
    logic [4:0]   b_wc;
    logic [5:0]   b_rc;
    logic         b_ovf, b_udf;

    logic [31:0]  c_din;
    logic         c_wr, c_rd;
    logic [63:0]  c_dout;
    logic         c_valid, c_full, c_empty, c_inr, c_outr;
    logic [4:0]   c_wc;
    logic [3:0]   c_rc;
    logic         c_ovf, c_udf;

    pipe_width_fifo u_a (
        .okClk(okClk), .reset_n(reset_n), .din(a_din), .wr_en(a_wr), .rd_en(a_rd),
`ifdef PIPE_FIFO_STATS_EN
        .clr_stats(tb_clr), .ovf(a_ovf), .udf(a_udf),
`endif
        .dout(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
        .wr_count(a_wc), .rd_count(a_rc), .in_ready(a_inr), .out_ready(a_outr)
    );

    pipe_width_fifo #(.WR_W(64), .RD_W(32), .WR_DEPTH(16), .BLK_WR(4), .BLK_RD(4), .MSB_FIRST(0)) u_b (
        .okClk(okClk), .reset_n(reset_n), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
`ifdef PIPE_FIFO_STATS_EN
        .clr_stats(tb_clr), .ovf(b_ovf), .udf(b_udf),
`endif
        .dout(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
        .wr_count(b_wc), .rd_count(b_rc), .in_ready(b_inr), .out_ready(b_outr)
    );

    pipe_width_fifo #(.WR_W(32), .RD_W(64), .WR_DEPTH(16), .BLK_WR(4), .BLK_RD(2), .MSB_FIRST(1)) u_c (
        .okClk(okClk), .reset_n(reset_n), .din(c_din), .wr_en(c_wr), .rd_en(c_rd),
`ifdef PIPE_FIFO_STATS_EN
        .clr_stats(tb_clr), .ovf(c_ovf), .udf(c_udf),
`endif
        .dout(c_dout), .valid(c_valid), .full(c_full), .empty(c_empty),
        .wr_count(c_wc), .rd_count(c_rc), .in_ready(c_inr), .out_ready(c_outr)
    );

    // Reference model for instance a: a queue of 32-bit words, reads take eight at a time.
    logic [31:0]  qa[$];
    logic         exp_valid;
    logic [255:0] exp_dout;
    logic         exp_inr, exp_outr, exp_udf;

    task automatic model_reset();
        qa.delete();
        exp_valid = 1'b0;
        exp_dout  = '0;
        exp_inr   = 1'b0;
        exp_outr  = 1'b0;
        exp_udf   = 1'b0;
    endtask

    task automatic idle_all();
        a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
    endtask

    // Drives one cycle of instance a, then advances the model and returns #1 after the edge.
    task automatic a_cycle(input logic wr, input logic rd, input logic [31:0] d);
        bit wok, rok;
        a_wr = wr; a_rd = rd; a_din = d;
        @(posedge okClk);
        wok = wr && (qa.size() < 1024);
        rok = rd && (qa.size() >= 8);
        exp_inr  = qa.size() <= 896;
        exp_outr = (qa.size() / 8) >= 128;
        exp_udf  = (exp_udf && !tb_clr) || (rd && !rok);
        exp_valid = rok;
        if (rok) begin
            for (int k = 0; k < 8; k++) exp_dout[k*32 +: 32] = qa.pop_front();
        end
        if (wok) qa.push_back(d);
        #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tb_clr  = 1'b0;
        idle_all();
        model_reset();
        repeat (2) @(posedge okClk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if (a_dout !== '0 || a_valid !== 1'b0 || a_full !== 1'b0 || a_empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags: dout=%h valid=%b full=%b empty=%b required dout=0 valid=0 full=0 empty=1",
                     a_dout, a_valid, a_full, a_empty);
        end
        total++;
        if (a_wc !== 11'd0 || a_rc !== 8'd0 || a_inr !== 1'b0 || a_outr !== 1'b0) begin
            bad++;
            $display("FAIL reset_counts: wc=%0d rc=%0d inr=%b outr=%b required 0 0 0 0", a_wc, a_rc, a_inr, a_outr);
        end
        reset_n = 1'b1;
        a_cycle(1'b0, 1'b0, '0);
        total++;
        if (a_inr !== 1'b1) begin
            bad++;
            $display("FAIL reset_inready_rise: in_ready=%b required 1", a_inr);
        end
    endtask

    task automatic test_first_word();
        logic [255:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_cycle(1'b1, 1'b0, 32'(i));
            want[i*32 +: 32] = 32'(i);
            total++;
            if (a_empty !== (i < 7)) begin
                bad++;
                $display("FAIL first_empty[%0d]: empty=%b required %b", i, a_empty, (i < 7));
            end
        end
        total++;
        if (a_rc !== 8'd1 || a_wc !== 11'd8) begin
            bad++;
            $display("FAIL first_counts: rc=%0d wc=%0d required 1 8", a_rc, a_wc);
        end
        a_cycle(1'b0, 1'b1, '0);
        total++;
        if (a_valid !== 1'b1 || a_dout !== want) begin
            bad++;
            $display("FAIL first_read: valid=%b dout=%h required 1 %h", a_valid, a_dout, want);
        end
        a_cycle(1'b0, 1'b0, '0);
        total++;
        if (a_valid !== 1'b0 || a_dout !== want) begin
            bad++;
            $display("FAIL first_hold: valid=%b dout=%h required 0 %h", a_valid, a_dout, want);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            a_cycle(1'b1, 1'b0, $urandom);
            total++;
            if (a_inr !== exp_inr || a_wc !== 11'(qa.size())) begin
                bad++;
                $display("FAIL fill_step[%0d]: inr=%b wc=%0d required %b %0d", i, a_inr, a_wc, exp_inr, qa.size());
            end
        end
        total++;
        if (a_full !== 1'b1 || a_wc !== 11'd1024 || a_rc !== 8'd128) begin
            bad++;
            $display("FAIL fill_full: full=%b wc=%0d rc=%0d required 1 1024 128", a_full, a_wc, a_rc);
        end
        a_cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
        total++;
        if (a_wc !== 11'd1024 || a_outr !== 1'b1) begin
            bad++;
            $display("FAIL fill_drop: wc=%0d outr=%b required 1024 1", a_wc, a_outr);
        end
        // Simultaneous read and write at full: only the read goes through.
        a_cycle(1'b1, 1'b1, 32'h1234_5678);
        total++;
        if (a_wc !== 11'd1016 || a_full !== 1'b0 || a_valid !== 1'b1 || a_dout !== exp_dout) begin
            bad++;
            $display("FAIL full_rw: wc=%0d full=%b valid=%b dout=%h required 1016 0 1 %h",
                     a_wc, a_full, a_valid, a_dout, exp_dout);
        end
        a_cycle(1'b1, 1'b0, 32'h0BAD_F00D);
        total++;
        if (a_wc !== 11'd1017) begin
            bad++;
            $display("FAIL full_rw_next: wc=%0d required 1017", a_wc);
        end
        while (qa.size() >= 8) begin
            a_cycle(1'b0, 1'b1, '0);
            total++;
            if (a_valid !== 1'b1 || a_dout !== exp_dout || a_rc !== 8'(qa.size() / 8) || a_outr !== exp_outr) begin
                bad++;
                $display("FAIL drain: valid=%b dout=%h rc=%0d outr=%b required 1 %h %0d %b",
                         a_valid, a_dout, a_rc, a_outr, exp_dout, qa.size() / 8, exp_outr);
            end
        end
    endtask

    task automatic test_random();
        bit wr, rd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 3);
            a_cycle(wr, rd, $urandom);
            total++;
            if (a_valid !== exp_valid || (exp_valid && a_dout !== exp_dout) ||
                a_full !== (qa.size() >= 1024) || a_empty !== (qa.size() < 8) ||
                a_wc !== 11'(qa.size()) || a_rc !== 8'(qa.size() / 8) ||
                a_inr !== exp_inr || a_outr !== exp_outr) begin
                bad++;
                $display("FAIL random[%0d]: valid=%b dout=%h wc=%0d rc=%0d inr=%b required %b %h %0d %0d %b",
                         i, a_valid, a_dout, a_wc, a_rc, a_inr, exp_valid, exp_dout, qa.size(), qa.size() / 8, exp_inr);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] want;
        do_reset();
        for (int i = 0; i < 300; i++) a_cycle(1'b1, (i % 50) == 49, $urandom);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (a_dout !== '0 || a_valid !== 1'b0 || a_full !== 1'b0 || a_empty !== 1'b1 ||
            a_wc !== 11'd0 || a_rc !== 8'd0 || a_inr !== 1'b0 || a_outr !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: dout=%h valid=%b empty=%b wc=%0d rc=%0d inr=%b outr=%b required all zero, empty=1",
                     a_dout, a_valid, a_empty, a_wc, a_rc, a_inr, a_outr);
        end
        model_reset();
        @(posedge okClk);
        #1;
        reset_n = 1'b1;
        a_cycle(1'b1, 1'b0, 32'h5);
        a_cycle(1'b0, 1'b1, '0);
        total++;
        if (a_valid !== 1'b0 || a_wc !== 11'd1) begin
            bad++;
            $display("FAIL reset_mid_partial: valid=%b wc=%0d required 0 1", a_valid, a_wc);
        end
        for (int i = 0; i < 7; i++) a_cycle(1'b1, 1'b0, 32'h0);
        a_cycle(1'b0, 1'b1, '0);
        want = 256'h5;
        total++;
        if (a_valid !== 1'b1 || a_dout !== want) begin
            bad++;
            $display("FAIL reset_mid_read: valid=%b dout=%h required 1 %h", a_valid, a_dout, want);
        end
    endtask

    task automatic test_wide_write();
        logic [31:0] qb[$];
        logic [63:0] w;
        logic [31:0] want;
        do_reset();
        b_din = 64'hAAAABBBB_CCCCDDDD; b_wr = 1'b1;
        @(posedge okClk); #1; b_wr = 1'b0;
        total++;
        if (b_rc !== 6'd2 || b_wc !== 5'd1) begin
            bad++;
            $display("FAIL wide_counts: rc=%0d wc=%0d required 2 1", b_rc, b_wc);
        end
        b_rd = 1'b1;
        @(posedge okClk); #1;
        total++;
        if (b_valid !== 1'b1 || b_dout !== 32'hCCCCDDDD || b_rc !== 6'd1 || b_wc !== 5'd0) begin
            bad++;
            $display("FAIL wide_read1: valid=%b dout=%h rc=%0d wc=%0d required 1 ccccdddd 1 0", b_valid, b_dout, b_rc, b_wc);
        end
        @(posedge okClk); #1; b_rd = 1'b0;
        total++;
        if (b_valid !== 1'b1 || b_dout !== 32'hAAAABBBB || b_rc !== 6'd0 || b_empty !== 1'b1) begin
            bad++;
            $display("FAIL wide_read2: valid=%b dout=%h rc=%0d empty=%b required 1 aaaabbbb 0 1", b_valid, b_dout, b_rc, b_empty);
        end
        // Fill past capacity (16 wide words), then drain in 32-bit pieces.
        for (int i = 0; i < 18; i++) begin
            w = {$urandom, $urandom};
            b_din = w; b_wr = 1'b1;
            @(posedge okClk); #1;
            if (i < 16) begin
                qb.push_back(w[31:0]);
                qb.push_back(w[63:32]);
            end
        end
        b_wr = 1'b0;
        total++;
        if (b_full !== 1'b1 || b_wc !== 5'd16 || b_rc !== 6'd32) begin
            bad++;
            $display("FAIL wide_full: full=%b wc=%0d rc=%0d required 1 16 32", b_full, b_wc, b_rc);
        end
        b_rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge okClk); #1;
            want = qb.pop_front();
            total++;
            if (b_valid !== 1'b1 || b_dout !== want || b_rc !== 6'(qb.size())) begin
                bad++;
                $display("FAIL wide_drain[%0d]: valid=%b dout=%h rc=%0d required 1 %h %0d", i, b_valid, b_dout, b_rc, want, qb.size());
            end
        end
        b_rd = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [31:0] qc[$];
        logic [31:0] w;
        logic [63:0] want;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            qc.push_back(w);
            c_din = w; c_wr = 1'b1;
            @(posedge okClk); #1;
        end
        c_wr = 1'b0;
        total++;
        if (c_wc !== 5'd10 || c_rc !== 4'd5) begin
            bad++;
            $display("FAIL msb_counts: wc=%0d rc=%0d required 10 5", c_wc, c_rc);
        end
        c_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge okClk); #1;
            want[63:32] = qc.pop_front();
            want[31:0]  = qc.pop_front();
            total++;
            if (c_valid !== 1'b1 || c_dout !== want) begin
                bad++;
                $display("FAIL msb_read[%0d]: valid=%b dout=%h required 1 %h", i, c_valid, c_dout, want);
            end
        end
        c_rd = 1'b0;
    endtask

`ifdef PIPE_FIFO_STATS_EN
    task automatic test_stats();
        do_reset();
        a_cycle(1'b0, 1'b1, '0);
        total++;
        if (a_udf !== 1'b1 || a_valid !== 1'b0 || a_ovf !== 1'b0) begin
            bad++;
            $display("FAIL stats_udf_set: udf=%b valid=%b ovf=%b required 1 0 0", a_udf, a_valid, a_ovf);
        end
        repeat (3) a_cycle(1'b0, 1'b0, '0);
        total++;
        if (a_udf !== exp_udf) begin
            bad++;
            $display("FAIL stats_udf_sticky: udf=%b required %b", a_udf, exp_udf);
        end
        tb_clr = 1'b1;
        a_cycle(1'b0, 1'b1, '0);
        total++;
        if (a_udf !== exp_udf) begin
            bad++;
            $display("FAIL stats_set_and_clear: udf=%b required %b", a_udf, exp_udf);
        end
        a_cycle(1'b0, 1'b0, '0);
        tb_clr = 1'b0;
        total++;
        if (a_udf !== exp_udf) begin
            bad++;
            $display("FAIL stats_udf_clear: udf=%b required %b", a_udf, exp_udf);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        tb_clr  = 1'b0;
        idle_all();
        model_reset();
        test_reset();
        test_first_word();
        test_fill_full();
        test_random();
        test_reset_mid();
        test_wide_write();
        test_msb_first();
`ifdef PIPE_FIFO_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
